// File: rtl/reg_file_banked.sv
// Banked register file: independent X/Y reads, a write port on ADRX, optional write bypass,
// a hardware clear sequencer, and single-cycle shadow save/restore of the low registers.
//
// Ports:
//   CLK             system clock; all state changes on the rising edge
//   RST             synchronous active-high reset; starts a full clear
//   ADRX / ADRY     X read address (also the write address) / Y read address
//   DIN, WR         write data and write enable
//   CLR             one-cycle pulse that starts a clear sequence
//   SAVE / RESTORE  copy the low registers to / from the shadow bank
//   DX_OUT / DY_OUT combinational read data
//   BUSY            high while the clear sequence is running
module reg_file_banked #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int SHADOW_N = 8,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ADRX,
    input  logic [ADDR_W-1:0] ADRY,
    input  logic [DATA_W-1:0] DIN,
    input  logic              WR,
    input  logic              CLR,
    input  logic              SAVE,
    input  logic              RESTORE,
    output logic [DATA_W-1:0] DX_OUT,
    output logic [DATA_W-1:0] DY_OUT,
    output logic              BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] CLEARING = 1'b1;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] SH_LIM   = (ADDR_W + 1)'(SHADOW_N);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    logic [0:0]        state;
    logic [ADDR_W:0]   idx;
    logic [DATA_W-1:0] ram    [DEPTH];
    logic [DATA_W-1:0] shadow [SHADOW_N];

    logic do_save;
    logic do_rest;
    logic wr_ok;

    // SAVE and RESTORE together cancel each other; a restore owns the low registers
    // for that cycle, so a write landing there is dropped.
    assign do_save = SAVE & ~RESTORE;
    assign do_rest = RESTORE & ~SAVE;
    assign wr_ok   = WR & ~(do_rest & ({1'b0, ADRX} < SH_LIM));

    assign BUSY = (state == CLEARING);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEARING;
            idx   <= '0;
            for (int i = 0; i < SHADOW_N; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            unique case (state)
                CLEARING: begin
                    ram[idx[ADDR_W-1:0]] <= '0;
                    idx <= idx + IDX_ONE;
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (CLR) begin
                        state <= CLEARING;
                        idx   <= '0;
                    end
                    if (do_save) begin
                        for (int i = 0; i < SHADOW_N; i++) begin
                            shadow[i] <= ram[i];
                        end
                    end
                    if (do_rest) begin
                        for (int i = 0; i < SHADOW_N; i++) begin
                            ram[i] <= shadow[i];
                        end
                    end
                    if (wr_ok) begin
                        ram[ADRX] <= DIN;
                    end
                end
            endcase
        end
    end

    // Bypass forwards DIN even when a concurrent restore discards the write.
    always_comb begin
        DX_OUT = ram[ADRX];
        DY_OUT = ram[ADRY];
        if ((BYPASS != 0) && WR) begin
            DX_OUT = DIN;
            if (ADRY == ADRX) begin
                DY_OUT = DIN;
            end
        end
        if (BUSY) begin
            DX_OUT = '0;
            DY_OUT = '0;
        end
    end

endmodule

// File: doc/reg_file_banked.md
Name: reg_file_banked

Overview:
- Parametrised successor to the MCU's 8x32 general-purpose register file.
- Independent X/Y read addresses. Write address is ADRX, per MCU convention.
- Optional write-to-read bypass.
- Hardware clear sequencer: one entry per cycle, on reset or on command.
- Single-cycle shadow save/restore of the low registers for interrupt context switching.
- Sits between the control unit and the ALU/output mux.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- SHADOW_N, 8: number of low registers (0..SHADOW_N-1) with a shadow copy; legal range 1..DEPTH.
- BYPASS, 1: 1 = same-cycle write data forwarded to the read outputs; 0 = reads show the pre-write array value.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- ADRX  in  ADR_W  X read address and write address.
- ADRY  in  ADR_W  Y read address.
- DIN  in  DATA_W  write data.
- WR  in  1  write enable.
- CLR  in  1  one-cycle pulse: start clear sequence.
- SAVE  in  1  copy regs 0..SHADOW_N-1 into shadow.
- RESTORE  in  1  copy shadow into regs 0..SHADOW_N-1.
- DX_OUT  out  DATA_W  X read data (combinational).
- DY_OUT  out  DATA_W  Y read data (combinational).
- BUSY  out  1  clear sequence in progress.

Behaviour:
- FSM states: IDLE and CLEARING. Clear index idx is ADDR_W+1 bits wide.
- RST high (checked at rising edge):
  - state <= CLEARING, idx <= 0.
  - All shadow entries <= 0 in parallel.
  - RST overrides every other input, including mid-clear: the sequence restarts from idx 0.
- CLEARING:
  - Each edge with RST low: ram[idx] <= 0, idx++.
  - After the edge that clears entry DEPTH-1: state <= IDLE.
  - BUSY is high for exactly DEPTH cycles after RST deasserts.
- IDLE:
  - CLR=1 -> CLEARING, idx <= 0. Shadow is not cleared by CLR.
  - CLR while CLEARING is ignored; the sequence is not restarted.
- BUSY = (state == CLEARING). BUSY is 1 during and after reset until the clear completes.
- While BUSY:
  - DX_OUT = DY_OUT = 0.
  - WR, SAVE and RESTORE are ignored; no array or shadow change.
- Reads, IDLE:
  - DX_OUT = ram[ADRX], DY_OUT = ram[ADRY], zero-latency.
  - With BYPASS=1 and WR=1: DX_OUT = DIN; DY_OUT = DIN if ADRY == ADRX.
- Write, IDLE: WR=1 -> ram[ADRX] <= DIN at the edge.
- SAVE (IDLE, RESTORE=0): shadow[i] <= ram[i] for all i < SHADOW_N. Captures pre-write values if WR is also asserted that cycle.
- RESTORE (IDLE, SAVE=0): ram[i] <= shadow[i] for i < SHADOW_N.
  - Concurrent WR to ADRX < SHADOW_N is discarded (RESTORE wins).
  - Concurrent WR to ADRX >= SHADOW_N proceeds normally.
  - Bypass output still shows DIN that cycle.
- SAVE and RESTORE both high: no-op for both. WR still applies.
- Widths: no arithmetic. Out-of-range addresses cannot occur (DEPTH = 2**ADDR_W).

Test Plan (defaults DATA_W=8, ADDR_W=5, SHADOW_N=8, BYPASS=1):
1. Reset clear: preload junk by backdoor, RST 1 cycle -> BUSY high 32 cycles then low; outputs 0 while BUSY; all 32 registers read 0x00 afterwards.
2. Write/read/bypass: WR ADRX=5 DIN=0xA5 with ADRY=5 -> DX_OUT=DY_OUT=0xA5 same cycle. Next cycle WR=0, ADRY=5 -> DY_OUT=0xA5. Repeat with BYPASS=0 -> write cycle shows 0x00.
3. Busy lockout: CLR pulse, then WR ADRX=3 DIN=0x11 on cycle 2 -> ignored; reg 3 = 0x00 after BUSY falls. A second CLR mid-sequence does not lengthen BUSY past 32 cycles.
4. Context switch: regs 0..7 = 0x10..0x17, SAVE; overwrite regs 0..7 with 0xFF; RESTORE -> regs 0..7 read 0x10..0x17. Reg 8 is unaffected.
5. Collisions: RESTORE + WR ADRX=2 DIN=0x55 -> reg2 = shadow value. RESTORE + WR ADRX=9 DIN=0x55 -> reg9 = 0x55. SAVE+RESTORE together -> shadow and regs 0..7 unchanged.
6. Reset mid-clear: CLR, then RST at cycle 10 -> BUSY stays high 32 cycles after RST deasserts; shadow reads back 0x00 via SAVE-free RESTORE.
